// File: rtl/noc_buf_defs.sv
// Shared NoC buffer definitions: clog2 and the count/index width rules
// used by the VC buffer and the router modules built around it.
package noc_buf_defs;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  // A count must reach DEPTH inclusive, hence the extra bit.
  function automatic int cw_of(input int depth);
    return clog2(depth) + 1;
  endfunction

  function automatic int vw_of(input int num_vc);
    return clog2(num_vc);
  endfunction

endpackage

// File: rtl/vc_fifo_core.sv
// One virtual channel: circular storage, read/write pointers, occupancy count
// and the empty/full/almost-full flags derived from that count.
module vc_fifo_core
  import noc_buf_defs::*;
#(
  parameter int NUM_BITS = 8,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = DEPTH - 2,
  localparam int CW      = cw_of(DEPTH),
  localparam int AW      = clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [NUM_BITS-1:0] wr_data,
  input  logic                pop,
  output logic [NUM_BITS-1:0] head,
  output logic [CW-1:0]       count,
  output logic                empty,
  output logic                full,
  output logic                almost_full
);

  logic [NUM_BITS-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign empty       = (count == '0);
  assign full        = (count == CW'(DEPTH));
  assign almost_full = (count >= CW'(AF_LEVEL));

  // Acceptance uses pre-edge flags, so popping a full VC never makes room
  // for a write landing on the same edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define which
  // entries are live, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (rst_n && do_push) mem[wr_ptr] <= wr_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/vc_buffer.sv
// Multi-VC input buffer: one vc_fifo_core per VC, a registered read port,
// per-VC credit return pulses and sticky overflow/underflow flags.
module vc_buffer
  import noc_buf_defs::*;
#(
  parameter int NUM_BITS = 8,
  parameter int DEPTH    = 8,
  parameter int NUM_VC   = 4,
  parameter int AF_LEVEL = DEPTH - 2,
  localparam int CW      = cw_of(DEPTH),
  localparam int VW      = vw_of(NUM_VC)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [VW-1:0]        wr_vc,
  input  logic [NUM_BITS-1:0]  wr_data,
  input  logic                 rd_en,
  input  logic [VW-1:0]        rd_vc,
  output logic [NUM_BITS-1:0]  rd_data,
  output logic                 rd_valid,
  output logic [NUM_VC-1:0]    empty,
  output logic [NUM_VC-1:0]    full,
  output logic [NUM_VC-1:0]    almost_full,
  output logic [NUM_VC*CW-1:0] count,
  output logic [NUM_VC-1:0]    credit,
  output logic                 ovf_err,
  output logic                 udf_err
);

  logic [NUM_VC-1:0]   wr_sel;
  logic [NUM_VC-1:0]   rd_sel;
  logic [NUM_BITS-1:0] head [NUM_VC];
  logic [NUM_BITS-1:0] rd_mux;
  logic                wr_ok;
  logic                rd_ok;

  // A VC index beyond NUM_VC selects nothing, so it is rejected and flagged.
  for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
    assign wr_sel[i] = wr_en && (wr_vc == VW'(i));
    assign rd_sel[i] = rd_en && (rd_vc == VW'(i));

    vc_fifo_core #(
      .NUM_BITS (NUM_BITS),
      .DEPTH    (DEPTH),
      .AF_LEVEL (AF_LEVEL)
    ) u_core (
      .clk         (clk),
      .rst_n       (rst_n),
      .push        (wr_sel[i]),
      .wr_data     (wr_data),
      .pop         (rd_sel[i]),
      .head        (head[i]),
      .count       (count[i*CW +: CW]),
      .empty       (empty[i]),
      .full        (full[i]),
      .almost_full (almost_full[i])
    );
  end

  assign wr_ok = |(wr_sel & ~full);
  assign rd_ok = |(rd_sel & ~empty);

  always_comb begin
    // NOTE: default assigned first so the mux cannot infer a latch.
    rd_mux = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (rd_sel[i]) rd_mux = head[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
      credit   <= '0;
      ovf_err  <= 1'b0;
      udf_err  <= 1'b0;
    end else begin
      if (rd_ok) rd_data <= rd_mux;
      rd_valid <= rd_ok;
      credit   <= rd_sel & ~empty;
      if (wr_en && !wr_ok) ovf_err <= 1'b1;
      if (rd_en && !rd_ok) udf_err <= 1'b1;
    end
  end

endmodule
